mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Sits between the instruction cache, the data cache and the main memory model.
- Takes line-refill reads and write-backs from both caches and serialises them onto one memory port, one transaction at a time.
- Data side has priority over instruction side, bounded by a starvation limit.
- Latches each request, holds the memory strobes until the memory reports ready, returns the line to the winning cache with a one-cycle ready pulse.

Parameters:
LINE_W, 128, cache line width in bits (multiple of 32, power of two)
MAX_CONSEC, 2, max back-to-back data grants while an instruction request is pending
TIMEOUT, 255, cycles in a grant state without mem_ready before err_timeout sets

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
rd_data_req  in  1  data cache line read request (level, held until ready_data)
wr_data_req  in  1  data cache write-back request (level, held until ready_data)
addr_data  in  32  data request byte address
wdata_data  in  LINE_W  write-back line
rdata_data  out  LINE_W  line returned for a data read
ready_data  out  1  one-cycle completion pulse, data side
rd_instr_req  in  1  instruction cache line read request (level)
addr_instr  in  32  instruction request byte address
rdata_instr  out  LINE_W  line returned for an instruction read
ready_instr  out  1  one-cycle completion pulse, instruction side
mem_oe  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  32  line-aligned memory address
mem_wdata  out  LINE_W  memory write data
mem_rdata  in  LINE_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, may stay high several cycles
err_timeout  out  1  sticky, set when a grant exceeds TIMEOUT cycles

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including rdata_*, mem_addr, mem_wdata; consec_d=0; timer=0; err_timeout=0. An in-flight memory transaction is abandoned; no ready pulse is issued after reset releases.
- States: IDLE, GNT_D, GNT_I, DONE.
- IDLE arbitration, sampled each cycle:
  - d_req = rd_data_req|wr_data_req.
  - Grant D if d_req && (!rd_instr_req || consec_d<MAX_CONSEC).
  - Else grant I if rd_instr_req.
  - Else stay IDLE and clear consec_d.
- On a D grant: consec_d increments, saturating at MAX_CONSEC.
- On an I grant: consec_d clears.
- Grant entry (registered, visible the cycle after the IDLE sample):
  - mem_addr = request address with the low log2(LINE_W/8) bits cleared.
  - Data side: mem_we=wr_data_req, mem_oe=!wr_data_req. If rd and wr are both high, only the write is performed.
  - mem_wdata = wdata_data for a write.
  - Instruction side: mem_oe=1, mem_we=0.
  - Address, data and strobes are latched. Later changes on request inputs are ignored until DONE.
- GNT_x: strobes held constant while mem_ready=0; timer increments each cycle.
  - When timer reaches TIMEOUT, err_timeout=1 (sticky until reset). The FSM keeps waiting.
- First cycle with mem_ready=1 in GNT_x:
  - Next edge: strobes drop to 0; timer clears; state DONE.
  - ready_x pulses for exactly one cycle.
  - For reads, rdata_x captures mem_rdata. For writes, rdata_data is unchanged.
  - rdata_x holds until the next read completion on that side.
- DONE: one dead cycle so the requester can drop its request and the memory can drop mem_ready; no strobes; then IDLE.
  - mem_ready still high in DONE/IDLE is ignored.
- Throughput:
  - Request sampled in cycle N → strobes from N+1.
  - mem_ready in cycle M → ready pulse and DONE at M+1, IDLE at M+2.
  - Earliest next strobes at M+3.
- The ready pulse goes only to the granted side; the other side's outputs are unchanged.
- Requests that appear during GNT/DONE are served in a later IDLE; nothing is lost because requests are level-held.
- Only one of mem_oe/mem_we is ever high; both are 0 outside GNT states.

Test Plan:
- Single instruction read:
  - Stimulus: rd_instr_req=1, addr_instr=0x0000_1034; memory returns mem_ready after 5 cycles with 0xA5A5...
  - Required: mem_oe=1 with mem_addr=0x0000_1030 for 5 cycles; ready_instr pulses 1 cycle; rdata_instr=0xA5A5...; rdata_data stays 0.
- Simultaneous requests:
  - Stimulus: rd_data_req and rd_instr_req asserted in the same cycle.
  - Required: data transaction first; the instruction transaction starts on strobes exactly 3 cycles after the data side's mem_ready.
- Starvation limit (MAX_CONSEC=2):
  - Stimulus: data requests held continuously, instruction request held.
  - Required: grant order D, D, I, D, D, I.
- Write-back:
  - Stimulus: wr_data_req=1 with rd_data_req=1, wdata=0x1122...
  - Required: mem_we=1, mem_oe=0, mem_wdata=0x1122...; ready_data pulses; rdata_data unchanged.
- Timeout (TIMEOUT=8):
  - Stimulus: mem_ready held 0 for 12 cycles, then 1.
  - Required: err_timeout=1 from the 9th grant cycle and remains 1; the transaction still completes normally.
- Reset mid-transaction:
  - Stimulus: reset=0 for 1 cycle during GNT_D.
  - Required: strobes and ready outputs go to 0 immediately (async); no ready_data pulse afterwards; a fresh request is re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Serialises I-cache refills and D-cache refills/write-backs onto one memory port; strobes one cycle after
// the IDLE sample, ready pulse one cycle after mem_ready, then a dead cycle. Requesters are held off by level.
module mem_req_arbiter #(
    parameter int LINE_W     = 128,
    parameter int MAX_CONSEC = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_data_req,
    input  logic              wr_data_req,
    input  logic [31:0]       addr_data,
    input  logic [LINE_W-1:0] wdata_data,
    output logic [LINE_W-1:0] rdata_data,
    output logic              ready_data,
    input  logic              rd_instr_req,
    input  logic [31:0]       addr_instr,
    output logic [LINE_W-1:0] rdata_instr,
    output logic              ready_instr,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);
    localparam int CNT_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CONSEC);
    localparam logic [TMR_W-1:0] TMO       = TMR_W'(TIMEOUT);
    localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  consec_q, consec_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              err_q, err_d;
    logic              mem_oe_q, mem_oe_d, mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_data_q, rdata_data_d, rdata_instr_q, rdata_instr_d;
    logic              ready_data_q, ready_data_d, ready_instr_q, ready_instr_d;
    logic              d_req;

    assign d_req = rd_data_req | wr_data_req;

    always_comb begin
        state_d       = state_q;
        consec_d      = consec_q;
        timer_d       = timer_q;
        err_d         = err_q;
        mem_oe_d      = mem_oe_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_data_d  = rdata_data_q;
        rdata_instr_d = rdata_instr_q;
        ready_data_d  = 1'b0;
        ready_instr_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (d_req && (!rd_instr_req || consec_q < MAX_C)) begin
                    state_d    = GNT_D;
                    consec_d   = (consec_q == MAX_C) ? MAX_C : consec_q + CNT_W'(1);
                    mem_addr_d = addr_data & ADDR_MASK;
                    // a simultaneous read+write performs only the write-back
                    mem_we_d   = wr_data_req;
                    mem_oe_d   = !wr_data_req;
                    if (wr_data_req) begin
                        mem_wdata_d = wdata_data;
                    end
                end else if (rd_instr_req) begin
                    state_d    = GNT_I;
                    consec_d   = '0;
                    mem_addr_d = addr_instr & ADDR_MASK;
                    mem_oe_d   = 1'b1;
                    mem_we_d   = 1'b0;
                end else begin
                    consec_d = '0;
                end
            end
            GNT_D, GNT_I: begin
                if (mem_ready) begin
                    state_d  = DONE;
                    mem_oe_d = 1'b0;
                    mem_we_d = 1'b0;
                    timer_d  = '0;
                    if (state_q == GNT_D) begin
                        ready_data_d = 1'b1;
                        if (!mem_we_q) begin
                            rdata_data_d = mem_rdata;
                        end
                    end else begin
                        ready_instr_d = 1'b1;
                        rdata_instr_d = mem_rdata;
                    end
                end else begin
                    // timer saturates; the error is sticky and the grant keeps waiting
                    if (timer_q != TMO) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (timer_d == TMO) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            consec_q      <= '0;
            timer_q       <= '0;
            err_q         <= 1'b0;
            mem_oe_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_data_q  <= '0;
            rdata_instr_q <= '0;
            ready_data_q  <= 1'b0;
            ready_instr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            consec_q      <= consec_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            mem_oe_q      <= mem_oe_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_data_q  <= rdata_data_d;
            rdata_instr_q <= rdata_instr_d;
            ready_data_q  <= ready_data_d;
            ready_instr_q <= ready_instr_d;
        end
    end

    assign mem_oe      = mem_oe_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata_data  = rdata_data_q;
    assign rdata_instr = rdata_instr_q;
    assign ready_data  = ready_data_q;
    assign ready_instr = ready_instr_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a transaction-level model with its own memory array.
module tb_mem_req_arbiter;
    localparam int LINE_W     = 128;
    localparam int MAX_CONSEC = 2;
    localparam int TIMEOUT    = 8;
    typedef logic [LINE_W-1:0] line_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_data_req, wr_data_req, rd_instr_req;
    logic [31:0] addr_data, addr_instr, mem_addr;
    line_t       wdata_data, rdata_data, rdata_instr, mem_wdata, mem_rdata;
    logic        ready_data, ready_instr, mem_oe, mem_we, mem_ready, err_timeout;

    int    n_chk = 0, n_pass = 0, cyc = 0;
    line_t exp_rd_d = '0, exp_rd_i = '0;

    mem_req_arbiter #(.LINE_W(LINE_W), .MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .rd_data_req(rd_data_req), .wr_data_req(wr_data_req), .addr_data(addr_data),
        .wdata_data(wdata_data), .rdata_data(rdata_data), .ready_data(ready_data),
        .rd_instr_req(rd_instr_req), .addr_instr(addr_instr), .rdata_instr(rdata_instr),
        .ready_instr(ready_instr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic chkl(input string nm, input line_t act, input line_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic drive_idle();
        rd_data_req  = 1'b0;
        wr_data_req  = 1'b0;
        rd_instr_req = 1'b0;
        mem_ready    = 1'b0;
    endtask

    typedef struct {
        logic        instr;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        line_t       wdata;
        line_t       rdata;
        int          lat;
        logic        oe;
        logic        we;
        logic [31:0] maddr;
    } vec_t;

    vec_t        vt[5];
    int          held, bad, bad_s, m_cyc, s_cyc, lat, streak;
    int          got[6];
    int          exp_order[6];
    logic        pd, pi, p_rd, p_wr, gd, e_we;
    logic [31:0] p_da, p_ia, la, ra;
    line_t       p_wd, rv;
    line_t       mem_m [logic [31:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_1034, 128'h0, {4{32'hA5A5_A5A5}}, 5, 1'b1, 1'b0, 32'h0000_1030};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_2008, 128'h0, {4{32'h0F0F_1234}}, 1, 1'b1, 1'b0, 32'h0000_2000};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_300C,
                  {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00},
                  {4{32'hBAD0_BAD0}}, 3, 1'b0, 1'b1, 32'h0000_3000};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, {4{32'hDEAD_BEEF}}, {4{32'hBAD1_BAD1}}, 2, 1'b0, 1'b1, 32'hFFFF_FFF0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_000F, 128'h0, {4{32'h600D_F00D}}, 1, 1'b1, 1'b0, 32'h0000_0000};
        exp_order = '{0, 0, 1, 0, 0, 1};

        // reset state, with a request pending that must be ignored
        reset = 1'b0;
        drive_idle();
        addr_data = '0; addr_instr = 32'h0000_0100; wdata_data = '0; mem_rdata = '0;
        rd_instr_req = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst_mem_oe", mem_oe, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chkl("rst_mem_wdata", mem_wdata, '0);
        chkl("rst_rdata_data", rdata_data, '0);
        chkl("rst_rdata_instr", rdata_instr, '0);
        chk1("rst_ready_data", ready_data, 1'b0);
        chk1("rst_ready_instr", ready_instr, 1'b0);
        chk1("rst_err", err_timeout, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        rd_instr_req = 1'b0;

        // isolated transactions from the vector table
        for (int v = 0; v < 5; v++) begin
            if (vt[v].instr) begin
                rd_instr_req = 1'b1; addr_instr = vt[v].addr;
            end else begin
                rd_data_req = vt[v].rd; wr_data_req = vt[v].wr;
                addr_data = vt[v].addr; wdata_data = vt[v].wdata;
            end
            held = 0;
            for (int g = 1; g <= vt[v].lat; g++) begin
                tick();
                mem_ready = (g == vt[v].lat);
                mem_rdata = vt[v].rdata;
                @(negedge clk);
                if (g == 1) begin
                    chk1($sformatf("vec%0d_oe", v), mem_oe, vt[v].oe);
                    chk1($sformatf("vec%0d_we", v), mem_we, vt[v].we);
                    chk32($sformatf("vec%0d_addr", v), mem_addr, vt[v].maddr);
                    if (vt[v].we) chkl($sformatf("vec%0d_wdata", v), mem_wdata, vt[v].wdata);
                end
                if (mem_oe === vt[v].oe && mem_we === vt[v].we && mem_addr === vt[v].maddr) held++;
            end
            chk32($sformatf("vec%0d_hold_cycles", v), held, vt[v].lat);
            tick();
            drive_idle();
            if (vt[v].instr) exp_rd_i = vt[v].rdata;
            else if (!vt[v].wr) exp_rd_d = vt[v].rdata;
            @(negedge clk);
            chk1($sformatf("vec%0d_ready_d", v), ready_data, !vt[v].instr);
            chk1($sformatf("vec%0d_ready_i", v), ready_instr, vt[v].instr);
            chk1($sformatf("vec%0d_done_strobes", v), mem_oe | mem_we, 1'b0);
            chkl($sformatf("vec%0d_rdata_d", v), rdata_data, exp_rd_d);
            chkl($sformatf("vec%0d_rdata_i", v), rdata_instr, exp_rd_i);
            tick();
            @(negedge clk);
            chk1($sformatf("vec%0d_ready_gone", v), ready_data | ready_instr, 1'b0);
        end

        // simultaneous requests: data first, instruction strobes 3 cycles after data mem_ready
        rd_data_req = 1'b1; addr_data = 32'h0000_5008;
        rd_instr_req = 1'b1; addr_instr = 32'h0000_6004;
        tick();
        mem_ready = 1'b1; mem_rdata = {4{32'h1111_5555}}; m_cyc = cyc;
        @(negedge clk);
        chk32("simul_first_addr", mem_addr, 32'h0000_5000);
        chk1("simul_first_oe", mem_oe, 1'b1);
        tick();
        rd_data_req = 1'b0;
        exp_rd_d = {4{32'h1111_5555}};
        @(negedge clk);
        chk1("simul_ready_d", ready_data, 1'b1);
        chk1("simul_no_ready_i", ready_instr, 1'b0);
        tick();
        mem_ready = 1'b0;
        s_cyc = -1;
        for (int k = 0; k < 6 && s_cyc < 0; k++) begin
            @(negedge clk);
            if (mem_oe === 1'b1 && mem_addr === 32'h0000_6000) s_cyc = cyc;
        end
        chk32("simul_instr_start_gap", s_cyc - m_cyc, 3);
        tick();
        mem_ready = 1'b1; mem_rdata = {4{32'h2222_6666}};
        tick();
        mem_ready = 1'b0; rd_instr_req = 1'b0;
        exp_rd_i = {4{32'h2222_6666}};
        @(negedge clk);
        chk1("simul_ready_i", ready_instr, 1'b1);
        chkl("simul_rdata_i", rdata_instr, exp_rd_i);
        chkl("simul_rdata_d_kept", rdata_data, exp_rd_d);
        tick();

        // starvation limit with both sides held continuously
        rd_data_req = 1'b1; addr_data = 32'h0000_7000;
        rd_instr_req = 1'b1; addr_instr = 32'h0000_8000;
        for (int g = 0; g < 6; g++) begin
            tick();
            mem_ready = 1'b1; mem_rdata = {4{32'h3333_7777}};
            @(negedge clk);
            if (mem_oe === 1'b1 && mem_addr === 32'h0000_7000) got[g] = 0;
            else if (mem_oe === 1'b1 && mem_addr === 32'h0000_8000) got[g] = 1;
            else got[g] = 2;
            tick();
            mem_ready = 1'b0;
            tick();
        end
        for (int g = 0; g < 6; g++) chk32($sformatf("starve_grant_%0d", g), got[g], exp_order[g]);
        exp_rd_d = {4{32'h3333_7777}};
        exp_rd_i = {4{32'h3333_7777}};
        chkl("starve_rdata_d", rdata_data, exp_rd_d);
        chkl("starve_rdata_i", rdata_instr, exp_rd_i);
        drive_idle();
        tick();

        // timeout: mem_ready low for 12 grant cycles, then high
        rd_data_req = 1'b1; addr_data = 32'h0000_9004;
        bad = 0; bad_s = 0;
        for (int g = 1; g <= 13; g++) begin
            tick();
            mem_ready = (g == 13); mem_rdata = {4{32'h4444_9999}};
            @(negedge clk);
            if (err_timeout !== (g >= 9)) bad++;
            if (mem_oe !== 1'b1 || mem_addr !== 32'h0000_9000) bad_s++;
        end
        chk32("timeout_err_profile", bad, 0);
        chk32("timeout_strobes_held", bad_s, 0);
        tick();
        drive_idle();
        exp_rd_d = {4{32'h4444_9999}};
        @(negedge clk);
        chk1("timeout_ready_d", ready_data, 1'b1);
        chkl("timeout_rdata_d", rdata_data, exp_rd_d);
        tick();
        @(negedge clk);
        chk1("timeout_err_sticky", err_timeout, 1'b1);

        // reset in the middle of a data grant
        rd_data_req = 1'b1; addr_data = 32'h4444_0010;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk1("midrst_oe", mem_oe, 1'b0);
        chk1("midrst_ready_d", ready_data, 1'b0);
        chk1("midrst_err", err_timeout, 1'b0);
        chk32("midrst_addr", mem_addr, 32'h0);
        chkl("midrst_rdata_d", rdata_data, '0);
        exp_rd_d = '0; exp_rd_i = '0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk1("midrst_no_late_ready", ready_data, 1'b0);
        chk1("midrst_idle_strobes", mem_oe | mem_we, 1'b0);
        tick();
        @(negedge clk);
        chk1("midrst_regrant_oe", mem_oe, 1'b1);
        chk32("midrst_regrant_addr", mem_addr, 32'h4444_0010);
        tick();
        addr_data = 32'h5555_5550; wr_data_req = 1'b1;
        mem_ready = 1'b1; mem_rdata = {4{32'h5A5A_0000}};
        @(negedge clk);
        chk32("latched_addr_ignores_input", mem_addr, 32'h4444_0010);
        chk1("latched_we_ignores_input", mem_we, 1'b0);
        tick();
        drive_idle();
        exp_rd_d = {4{32'h5A5A_0000}};
        @(negedge clk);
        chk1("midrst_ready_d", ready_data, 1'b1);
        chkl("midrst_final_rdata_d", rdata_data, exp_rd_d);
        tick();
        tick();

        // randomized traffic against a transaction-level model
        pd = 1'b0; pi = 1'b0; streak = 0;
        p_rd = 1'b0; p_wr = 1'b0; p_da = '0; p_ia = '0; p_wd = '0;
        for (int r = 0; r < 60; r++) begin
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1'b1;
                ra = 32'($urandom_range(0, 2));
                p_rd = (ra != 1); p_wr = (ra != 0);
                p_da = 32'h0000_A000 + 32'($urandom_range(0, 127));
                p_wd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1;
                p_ia = 32'h0000_A000 + 32'($urandom_range(0, 127));
            end
            rd_data_req = pd & p_rd; wr_data_req = pd & p_wr;
            addr_data = p_da; wdata_data = p_wd;
            rd_instr_req = pi; addr_instr = p_ia;
            @(negedge clk);
            chk1("rnd_idle_ready", ready_data | ready_instr, 1'b0);
            chk1("rnd_idle_strobes", mem_oe | mem_we, 1'b0);
            if (!pd && !pi) begin
                streak = 0;
                tick();
                continue;
            end
            gd   = pd && (!pi || streak < MAX_CONSEC);
            e_we = gd && p_wr;
            ra   = gd ? p_da : p_ia;
            la   = ra - (ra % (LINE_W / 8));
            rv   = mem_m.exists(la) ? mem_m[la] : ({4{la}} ^ {4{32'h5A5A_0F0F}});
            lat  = $urandom_range(1, 4);
            held = 0;
            for (int g = 1; g <= lat; g++) begin
                tick();
                mem_ready = (g == lat); mem_rdata = rv;
                @(negedge clk);
                if (g == 1) begin
                    chk1("rnd_we", mem_we, e_we);
                    chk1("rnd_oe", mem_oe, !e_we);
                    chk32("rnd_addr", mem_addr, la);
                    if (e_we) chkl("rnd_wdata", mem_wdata, p_wd);
                end
                if (mem_we === e_we && mem_oe === !e_we && mem_addr === la) held++;
            end
            chk32("rnd_hold_cycles", held, lat);
            tick();
            mem_ready = ($urandom_range(0, 1) == 1);
            if (gd) begin
                streak = (streak + 1 > MAX_CONSEC) ? MAX_CONSEC : streak + 1;
                if (e_we) mem_m[la] = p_wd;
                else exp_rd_d = rv;
                pd = 1'b0; rd_data_req = 1'b0; wr_data_req = 1'b0;
            end else begin
                streak = 0;
                exp_rd_i = rv;
                pi = 1'b0; rd_instr_req = 1'b0;
            end
            @(negedge clk);
            chk1("rnd_ready_d", ready_data, gd);
            chk1("rnd_ready_i", ready_instr, !gd);
            chk1("rnd_done_strobes", mem_oe | mem_we, 1'b0);
            chkl("rnd_rdata_d", rdata_data, exp_rd_d);
            chkl("rnd_rdata_i", rdata_instr, exp_rd_i);
            tick();
            mem_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
